// File: rtl/exu_mc.sv
// Multi-cycle execute stage: ALU, branch/jump resolution and load/store alignment
// in front of a request/response data-memory port. Optional macro: EXU_MC_MISALIGN_CHK_EN.
module exu_mc #(
  parameter  int XLEN   = 32,
  localparam int SHW    = $clog2(XLEN),
  localparam int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [4:0]        in_rd,
  input  logic [3:0]        in_alu_op,
  input  logic [2:0]        in_funct3,
  input  logic              in_use_imm,
  input  logic              in_reg_wen,
  input  logic              in_load,
  input  logic              in_store,
  input  logic              in_branch,
  input  logic              in_jal,
  input  logic              in_jalr,
  input  logic              in_auipc,
  input  logic              in_ebreak,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [STRB_W-1:0] mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic              out_reg_wen,
  output logic [XLEN-1:0]   out_wb_data,
  output logic              out_redirect,
  output logic [XLEN-1:0]   out_target,
  output logic              out_ebreak,
  output logic              out_exc,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // valid never depends on ready, and payload is held stable while valid waits.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_EXEC     = 3'd1;
  localparam logic [2:0] S_MEM_REQ  = 3'd2;
  localparam logic [2:0] S_MEM_WAIT = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam int OFF_W = $clog2(STRB_W);

  logic [2:0]        state_q, state_d;
  logic [XLEN-1:0]   pc_q, rs1_q, rs2_q, imm_q;
  logic [4:0]        rd_q;
  logic [3:0]        alu_op_q;
  logic [2:0]        funct3_q;
  logic              use_imm_q, reg_wen_q, load_q, store_q, branch_q;
  logic              jal_q, jalr_q, auipc_q, ebreak_q;
  logic [XLEN-1:0]   wb_q, target_q, addr_q, wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              redirect_q, wen_q, exc_q;

  logic [XLEN-1:0]   src2, alu_res, pc_imm, pc_4, rs1_imm, exec_wb, exec_target;
  logic [SHW-1:0]    shamt;
  logic              br_taken, redirect, mis_trap;
  logic [OFF_W-1:0]  st_off, ld_off;
  logic [STRB_W-1:0] st_strb;
  logic [XLEN-1:0]   st_wdata, ld_sh, ld_data;

  assign src2    = use_imm_q ? imm_q : rs2_q;
  assign shamt   = src2[SHW-1:0];
  assign pc_imm  = pc_q + imm_q;
  assign pc_4    = pc_q + XLEN'(4);
  assign rs1_imm = rs1_q + imm_q;

  always_comb begin
    alu_res = rs1_q + src2;
    case (alu_op_q)
      4'd1: alu_res = rs1_q - src2;
      4'd2: alu_res = rs1_q & src2;
      4'd3: alu_res = rs1_q | src2;
      4'd4: alu_res = rs1_q ^ src2;
      4'd5: alu_res = rs1_q << shamt;
      4'd6: alu_res = rs1_q >> shamt;
      4'd7: alu_res = $unsigned($signed(rs1_q) >>> shamt);
      4'd8: alu_res = XLEN'($signed(rs1_q) < $signed(src2));
      4'd9: alu_res = XLEN'(rs1_q < src2);
      default: alu_res = rs1_q + src2;
    endcase
  end

  // Branch comparator looks only at rs1/rs2, never at alu_op or the immediate.
  always_comb begin
    br_taken = 1'b0;
    case (funct3_q)
      3'b000: br_taken = (rs1_q == rs2_q);
      3'b001: br_taken = (rs1_q != rs2_q);
      3'b100: br_taken = ($signed(rs1_q) < $signed(rs2_q));
      3'b101: br_taken = !($signed(rs1_q) < $signed(rs2_q));
      3'b110: br_taken = (rs1_q < rs2_q);
      3'b111: br_taken = !(rs1_q < rs2_q);
      default: br_taken = 1'b0;
    endcase
  end

  assign redirect    = jal_q | jalr_q | (branch_q & br_taken);
  assign exec_target = jalr_q ? (rs1_imm & ~XLEN'(1)) : pc_imm;
  assign exec_wb     = (jal_q | jalr_q) ? pc_4 : (auipc_q ? pc_imm : alu_res);

  // Store lanes: data is replicated across the word so every lane carries it;
  // the strobe picks the addressed bytes.
  assign st_off = rs1_imm[OFF_W-1:0];
  always_comb begin
    st_strb  = '0;
    st_wdata = rs2_q;
    case (funct3_q)
      3'b000: begin
        st_strb  = STRB_W'(1) << st_off;
        st_wdata = {STRB_W{rs2_q[7:0]}};
      end
      3'b001: begin
        st_strb  = STRB_W'(3) << (st_off & ~OFF_W'(1));
        st_wdata = {(STRB_W/2){rs2_q[15:0]}};
      end
      3'b010: begin
        st_strb  = STRB_W'(4'hF) << (st_off & ~OFF_W'(3));
        st_wdata = {(XLEN/32){rs2_q[31:0]}};
      end
      3'b011: begin
        st_strb  = (XLEN == 64) ? '1 : '0;
        st_wdata = rs2_q;
      end
      default: begin
        st_strb  = '0;
        st_wdata = rs2_q;
      end
    endcase
  end

`ifdef EXU_MC_MISALIGN_CHK_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (funct3_q[1:0])
      2'b01:   misaligned = rs1_imm[0];
      2'b10:   misaligned = |rs1_imm[1:0];
      2'b11:   misaligned = |rs1_imm[2:0];
      default: misaligned = 1'b0;
    endcase
    mis_trap = (load_q | store_q) & misaligned;
  end
`else
  assign mis_trap = 1'b0;
`endif

  assign ld_off = addr_q[OFF_W-1:0];
  assign ld_sh  = mem_rsp_rdata >> {ld_off, 3'b000};
  always_comb begin
    ld_data = ld_sh;
    case (funct3_q)
      3'b000: ld_data = XLEN'($signed(ld_sh[7:0]));
      3'b001: ld_data = XLEN'($signed(ld_sh[15:0]));
      3'b010: ld_data = XLEN'($signed(ld_sh[31:0]));
      3'b100: ld_data = XLEN'(ld_sh[7:0]);
      3'b101: ld_data = XLEN'(ld_sh[15:0]);
      3'b110: ld_data = XLEN'(ld_sh[31:0]);
      default: ld_data = ld_sh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (in_valid) state_d = S_EXEC;
      S_EXEC:     state_d = (!mis_trap && (load_q || store_q)) ? S_MEM_REQ : S_DONE;
      S_MEM_REQ:  if (mem_req_ready) state_d = store_q ? S_DONE : S_MEM_WAIT;
      S_MEM_WAIT: if (mem_rsp_valid) state_d = S_DONE;
      S_DONE:     if (out_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0; rs1_q <= '0; rs2_q <= '0; imm_q <= '0;
      rd_q     <= '0; alu_op_q <= '0; funct3_q <= '0;
      use_imm_q <= 1'b0; reg_wen_q <= 1'b0; load_q <= 1'b0; store_q <= 1'b0;
      branch_q <= 1'b0; jal_q <= 1'b0; jalr_q <= 1'b0; auipc_q <= 1'b0; ebreak_q <= 1'b0;
      wb_q     <= '0; target_q <= '0; addr_q <= '0; wdata_q <= '0; wstrb_q <= '0;
      redirect_q <= 1'b0; wen_q <= 1'b0; exc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (in_valid) begin
          pc_q <= in_pc; rs1_q <= in_rs1_data; rs2_q <= in_rs2_data; imm_q <= in_imm;
          rd_q <= in_rd; alu_op_q <= in_alu_op; funct3_q <= in_funct3;
          use_imm_q <= in_use_imm; reg_wen_q <= in_reg_wen; load_q <= in_load;
          store_q <= in_store; branch_q <= in_branch; jal_q <= in_jal;
          jalr_q <= in_jalr; auipc_q <= in_auipc; ebreak_q <= in_ebreak;
        end
        S_EXEC: begin
          wb_q       <= exec_wb;
          redirect_q <= redirect;
          target_q   <= redirect ? exec_target : '0;
          wen_q      <= reg_wen_q & (rd_q != 5'd0) & ~mis_trap;
          exc_q      <= mis_trap;
          addr_q     <= rs1_imm;
          wdata_q    <= st_wdata;
          wstrb_q    <= store_q ? st_strb : '0;
        end
        S_MEM_WAIT: if (mem_rsp_valid) wb_q <= ld_data;
        default: ;
      endcase
    end
  end

  logic in_req, in_done;
  assign in_req  = (state_q == S_MEM_REQ);
  assign in_done = (state_q == S_DONE);

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = in_req;
  assign mem_req_wen   = in_req & store_q;
  assign mem_req_addr  = in_req ? addr_q  : '0;
  assign mem_req_wdata = in_req ? wdata_q : '0;
  assign mem_req_wstrb = in_req ? wstrb_q : '0;
  assign out_valid     = in_done;
  assign out_rd        = in_done ? rd_q : '0;
  assign out_reg_wen   = in_done & wen_q;
  assign out_wb_data   = in_done ? wb_q : '0;
  assign out_redirect  = in_done & redirect_q;
  assign out_target    = in_done ? target_q : '0;
  assign out_ebreak    = in_done & ebreak_q;
  assign out_exc       = in_done & exc_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_exu_mc.sv
// Directed bench for exu_mc: expected retirements queue up at issue, a negedge
// monitor pops and compares each one as writeback consumes it.
module tb_exu_mc;
  localparam int XLEN = 32;

  logic clk, rst;
  logic in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rd;
  logic [3:0]  in_alu_op;
  logic [2:0]  in_funct3;
  logic in_use_imm, in_reg_wen, in_load, in_store, in_branch, in_jal, in_jalr, in_auipc, in_ebreak;
  logic mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic out_valid, out_ready, out_reg_wen, out_redirect, out_ebreak, out_exc;
  logic [4:0]  out_rd;
  logic [31:0] out_wb_data, out_target;
  logic [2:0]  dbg_state;

  exu_mc #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rd(in_rd), .in_alu_op(in_alu_op), .in_funct3(in_funct3),
    .in_use_imm(in_use_imm), .in_reg_wen(in_reg_wen), .in_load(in_load),
    .in_store(in_store), .in_branch(in_branch), .in_jal(in_jal), .in_jalr(in_jalr),
    .in_auipc(in_auipc), .in_ebreak(in_ebreak),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_reg_wen(out_reg_wen),
    .out_wb_data(out_wb_data), .out_redirect(out_redirect), .out_target(out_target),
    .out_ebreak(out_ebreak), .out_exc(out_exc), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [72:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [72:0] pack(input logic [4:0] rd, input logic wen, input logic [31:0] wb,
                                       input logic redir, input logic [31:0] tgt,
                                       input logic ebrk, input logic exc);
    return {rd, wen, wb, redir, tgt, ebrk, exc};
  endfunction

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_unexpected: got %h expected nothing",
                 pack(out_rd, out_reg_wen, out_wb_data, out_redirect, out_target, out_ebreak, out_exc));
      end else begin
        check("out_result",
              pack(out_rd, out_reg_wen, out_wb_data, out_redirect, out_target, out_ebreak, out_exc),
              exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_in();
    in_valid = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_rd = 0;
    in_alu_op = 0; in_funct3 = 0; in_use_imm = 0; in_reg_wen = 0; in_load = 0; in_store = 0;
    in_branch = 0; in_jal = 0; in_jalr = 0; in_auipc = 0; in_ebreak = 0;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [4:0] rd, input logic [3:0] op,
                           input logic [2:0] f3, input logic ui, input logic wen);
    clear_in();
    in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm; in_rd = rd;
    in_alu_op = op; in_funct3 = f3; in_use_imm = ui; in_reg_wen = wen;
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic accept();
    int t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    check("accept_ready", in_ready, 1);
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    step();
    while (!out_valid && t < 50) begin step(); t++; end
    check(name, out_valid, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    step();
    while (!in_ready && t < 50) begin step(); t++; end
    check("back_to_idle", in_ready, 1);
  endtask

  task automatic alu_case(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic ui, input logic [31:0] res);
    set_instr(32'h0, a, b, imm, 5'd4, op, 3'b000, ui, 1'b1);
    exp_q.push_back(pack(5'd4, 1'b1, res, 1'b0, 32'h0, 1'b0, 1'b0));
    accept();
    wait_done("alu_done");
    wait_idle();
  endtask

  task automatic branch_case(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] imm, input logic taken,
                             input logic [31:0] tgt, input logic [31:0] sum);
    set_instr(pc, a, b, imm, 5'd0, 4'd0, f3, 1'b0, 1'b0);
    in_branch = 1;
    exp_q.push_back(pack(5'd0, 1'b0, sum, taken, tgt, 1'b0, 1'b0));
    accept();
    wait_done("branch_done");
    wait_idle();
  endtask

  task automatic store_case(input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                            input logic [2:0] f3, input logic [3:0] strb, input logic chk_wd,
                            input logic [31:0] wd);
    set_instr(32'h0, rs1, rs2, imm, 5'd0, 4'd0, f3, 1'b1, 1'b0);
    in_store = 1;
    exp_q.push_back(pack(5'd0, 1'b0, rs1 + imm, 1'b0, 32'h0, 1'b0, 1'b0));
    accept();
    step();
    step();
    check("st_req_valid", mem_req_valid, 1);
    check("st_req_addr", mem_req_addr, rs1 + imm);
    check("st_req_strb", mem_req_wstrb, strb);
    if (chk_wd) check("st_req_wdata", mem_req_wdata, wd);
    step();
    check("st_done", out_valid, 1);
    wait_idle();
  endtask

  task automatic load_case(input logic [31:0] rs1, input logic [31:0] imm, input logic [2:0] f3,
                           input logic [31:0] rdata, input int lat, input logic [31:0] res);
    set_instr(32'h0, rs1, 32'h0, imm, 5'd5, 4'd0, f3, 1'b1, 1'b1);
    in_load = 1;
    exp_q.push_back(pack(5'd5, 1'b1, res, 1'b0, 32'h0, 1'b0, 1'b0));
    accept();
    step();
    step();
    check("ld_req_valid", mem_req_valid, 1);
    check("ld_req_wen", mem_req_wen, 0);
    check("ld_req_addr", mem_req_addr, rs1 + imm);
    step();
    for (int i = 0; i < lat; i++) begin
      check("ld_wait_state", dbg_state, 3);
      check("ld_wait_novalid", out_valid, 0);
      step();
    end
    mem_rsp_valid = 1;
    mem_rsp_rdata = rdata;
    step();
    mem_rsp_valid = 0;
    mem_rsp_rdata = 32'h0;
    check("ld_done", out_valid, 1);
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1;
    clear_in();
    mem_req_ready = 0;
    mem_rsp_valid = 0;
    mem_rsp_rdata = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_state", dbg_state, 0);
    check("rst_outs", {out_rd, out_reg_wen, out_wb_data, out_redirect, out_target, out_ebreak, out_exc}, 0);
    @(posedge clk);
    #1 rst = 0;
    mem_req_ready = 1;

    // ADD with exact latency: EXEC cycle, then DONE
    set_instr(32'h0, 32'd5, 32'd7, 32'h0, 5'd3, 4'd0, 3'b000, 1'b0, 1'b1);
    exp_q.push_back(pack(5'd3, 1'b1, 32'd12, 1'b0, 32'h0, 1'b0, 1'b0));
    accept();
    step();
    check("add_exec_novalid", out_valid, 0);
    step();
    check("add_valid_at_2", out_valid, 1);
    wait_idle();

    alu_case(4'd1, 32'd5, 32'd7, 32'h0, 1'b0, 32'hFFFF_FFFE);
    alu_case(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 1'b0, 32'h0000_F000);
    alu_case(4'd3, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0, 1'b0, 32'h0000_FFFF);
    alu_case(4'd4, 32'h0000_00FF, 32'h0000_000F, 32'h0, 1'b0, 32'h0000_00F0);
    alu_case(4'd5, 32'd3, 32'h0, 32'd33, 1'b1, 32'd6);
    alu_case(4'd6, 32'h8000_0000, 32'd4, 32'h0, 1'b0, 32'h0800_0000);
    alu_case(4'd7, 32'h8000_0000, 32'd4, 32'h0, 1'b0, 32'hF800_0000);
    alu_case(4'd8, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 32'd1);
    alu_case(4'd9, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 32'd0);
    alu_case(4'd15, 32'd2, 32'd3, 32'h0, 1'b0, 32'd5);

    // AUIPC: pc+imm, not rs1+imm
    set_instr(32'h0000_1000, 32'h0, 32'h0, 32'h0000_2000, 5'd6, 4'd0, 3'b000, 1'b1, 1'b1);
    in_auipc = 1;
    exp_q.push_back(pack(5'd6, 1'b1, 32'h0000_3000, 1'b0, 32'h0, 1'b0, 1'b0));
    accept();
    wait_done("auipc_done");
    wait_idle();

    branch_case(3'b001, 32'h8000_0000, 32'd1, 32'd2, 32'h10, 1'b1, 32'h8000_0010, 32'd3);
    branch_case(3'b001, 32'h8000_0000, 32'd2, 32'd2, 32'h10, 1'b0, 32'h0, 32'd4);
    branch_case(3'b100, 32'h0000_0200, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b1, 32'h0000_0220, 32'd0);
    branch_case(3'b110, 32'h0000_0200, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0, 32'd0);
    branch_case(3'b111, 32'h0000_0300, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 1'b1, 32'h0000_02F8, 32'd0);
    branch_case(3'b010, 32'h0000_0300, 32'd0, 32'd0, 32'h40, 1'b0, 32'h0, 32'd0);

    // JAL
    set_instr(32'h0000_0100, 32'h0, 32'h0, 32'h40, 5'd1, 4'd0, 3'b000, 1'b1, 1'b1);
    in_jal = 1;
    exp_q.push_back(pack(5'd1, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0140, 1'b0, 1'b0));
    accept();
    wait_done("jal_done");
    wait_idle();

    // EBREAK with rd=0: write enable must be suppressed
    set_instr(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'd0, 3'b000, 1'b0, 1'b1);
    in_ebreak = 1;
    exp_q.push_back(pack(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
    accept();
    wait_done("ebreak_done");
    wait_idle();

    // JALR with writeback stalled for 4 cycles
    out_ready = 0;
    set_instr(32'h8000_0020, 32'h8000_0005, 32'h0, 32'h0, 5'd1, 4'd0, 3'b000, 1'b1, 1'b1);
    in_jalr = 1;
    exp_q.push_back(pack(5'd1, 1'b1, 32'h8000_0024, 1'b1, 32'h8000_0004, 1'b0, 1'b0));
    accept();
    wait_done("jalr_done");
    for (int i = 0; i < 4; i++) begin
      check("jalr_hold_wb", out_wb_data, 32'h8000_0024);
      check("jalr_hold_tgt", out_target, 32'h8000_0004);
      check("jalr_hold_redir", out_redirect, 1);
      check("jalr_hold_in_ready", in_ready, 0);
      step();
    end
    @(posedge clk);
    #1 out_ready = 1;
    step();
    wait_idle();

    // SB with the memory stalling the request for 3 cycles
    mem_req_ready = 0;
    set_instr(32'h0, 32'h8000_0100, 32'h0000_00AB, 32'd3, 5'd0, 4'd0, 3'b000, 1'b1, 1'b0);
    in_store = 1;
    exp_q.push_back(pack(5'd0, 1'b0, 32'h8000_0103, 1'b0, 32'h0, 1'b0, 1'b0));
    accept();
    step();
    check("sb_exec_noreq", mem_req_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("sb_req_valid", mem_req_valid, 1);
      check("sb_req_wen", mem_req_wen, 1);
      check("sb_req_addr", mem_req_addr, 32'h8000_0103);
      check("sb_req_strb", mem_req_wstrb, 4'b1000);
      check("sb_req_byte", mem_req_wdata[31:24], 8'hAB);
    end
    mem_req_ready = 1;
    step();
    check("sb_done", out_valid, 1);
    check("sb_req_dropped", mem_req_valid, 0);
    wait_idle();

    store_case(32'h8000_0000, 32'd2, 32'h0000_1234, 3'b001, 4'b1100, 1'b1, 32'h1234_1234);
    store_case(32'h8000_0400, 32'd0, 32'hCAFE_BABE, 3'b010, 4'b1111, 1'b1, 32'hCAFE_BABE);
    store_case(32'h8000_0400, 32'd1, 32'h0000_0055, 3'b000, 4'b0010, 1'b1, 32'h5555_5555);
    store_case(32'h8000_0400, 32'd0, 32'h0000_0055, 3'b100, 4'b0000, 1'b0, 32'h0);

    load_case(32'h8000_0200, 32'd2, 3'b000, 32'h00F0_0000, 5, 32'hFFFF_FFF0);
    load_case(32'h8000_0200, 32'd2, 3'b100, 32'h00F0_0000, 5, 32'h0000_00F0);
    load_case(32'h8000_0200, 32'd2, 3'b001, 32'h8001_0000, 0, 32'hFFFF_8001);
    load_case(32'h8000_0200, 32'd2, 3'b101, 32'h8001_0000, 0, 32'h0000_8001);
    load_case(32'h8000_0200, 32'd0, 3'b010, 32'h1234_5678, 1, 32'h1234_5678);

    // Reset during MEM_REQ: request must drop the cycle after rst
    mem_req_ready = 0;
    set_instr(32'h0, 32'h8000_0300, 32'h1, 32'h0, 5'd0, 4'd0, 3'b010, 1'b1, 1'b0);
    in_store = 1;
    accept();
    step();
    step();
    check("rstreq_req_valid", mem_req_valid, 1);
    rst = 1;
    step();
    check("rstreq_req_dropped", mem_req_valid, 0);
    rst = 0;
    mem_req_ready = 1;

    // Reset during MEM_WAIT, then a stale response
    set_instr(32'h0, 32'h8000_0300, 32'h0, 32'h0, 5'd5, 4'd0, 3'b010, 1'b1, 1'b1);
    in_load = 1;
    accept();
    step();
    step();
    step();
    check("rstwait_state", dbg_state, 3);
    rst = 1;
    step();
    rst = 0;
    check("rstwait_idle", dbg_state, 0);
    mem_rsp_valid = 1;
    mem_rsp_rdata = 32'hDEAD_BEEF;
    step();
    mem_rsp_valid = 0;
    check("rstwait_rsp_ignored_state", dbg_state, 0);
    check("rstwait_no_valid", out_valid, 0);
    step();
    check("rstwait_in_ready", in_ready, 1);
    alu_case(4'd0, 32'd10, 32'd20, 32'h0, 1'b0, 32'd30);

`ifdef EXU_MC_MISALIGN_CHK_EN
    set_instr(32'h0, 32'h8000_0000, 32'h0, 32'd2, 5'd7, 4'd0, 3'b010, 1'b1, 1'b1);
    in_load = 1;
    exp_q.push_back(pack(5'd7, 1'b0, 32'h8000_0002, 1'b0, 32'h0, 1'b0, 1'b1));
    accept();
    step();
    check("mis_exec_noreq", mem_req_valid, 0);
    step();
    check("mis_done_noreq", mem_req_valid, 0);
    check("mis_done", out_valid, 1);
    wait_idle();
`else
    load_case(32'h8000_0000, 32'd2, 3'b010, 32'h1122_3344, 0, 32'h0000_1122);
`endif

    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
